seq_magnitude_comparator: RTL
=============================

Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle successor to the combinational 2-bit equality checker. Compares two WIDTH-bit operands CHUNK bits per clock, most-significant chunk first, and reports eq/lt/gt in unsigned or two's-complement signed mode. By default it stops scanning at the first differing chunk. It sits between a producer and a consumer, with valid/ready handshakes on both the operand and result sides.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits compared per SCAN cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK must be at least 1.
EARLY_EXIT, 1, 1 = finish at the first differing chunk; 0 = always scan all NCHUNK chunks (constant-time).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands x, y and is_signed are valid.
in_ready  output  1  block can accept operands.
x  input  WIDTH  operand A.
y  input  WIDTH  operand B.
is_signed  input  1  1 = two's-complement compare; sampled with the operands.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts the result.
eq  output  1  x == y.
lt  output  1  x < y.
gt  output  1  x > y.
cycles  output  $clog2(NCHUNK+1)  number of SCAN cycles used for this result.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; out_valid, eq, lt, gt and cycles go to 0; internal operand registers and the chunk index are cleared.
  - Reset overrides any SCAN or DONE in progress; the partial result is discarded.
  - in_ready is gated combinationally and is 0 while rst_n=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch x, y and is_signed into internal registers; idx=NCHUNK-1; cycles=0; go to SCAN.
  - If is_signed=1, the MSB of both latched operands is inverted at capture. This maps signed order onto unsigned order.
- SCAN:
  - in_ready=0, out_valid=0.
  - Each cycle compares chunk idx of the latched operands (bits idx*CHUNK+CHUNK-1 down to idx*CHUNK) as unsigned values, and increments cycles.
  - First differing chunk: lt or gt is set from that chunk compare.
    - EARLY_EXIT=1: go to DONE at the end of this cycle.
    - EARLY_EXIT=0: the result is frozen; later chunks never overwrite it.
  - At idx==0: if no difference was found, eq=1; go to DONE.
  - Otherwise: idx decrements.
- Latency, measured from the in_valid&&in_ready edge to out_valid high:
  - EARLY_EXIT=1: k cycles, where k is the 1-based position of the first differing chunk from the MSB; NCHUNK if the operands are equal.
  - EARLY_EXIT=0: always NCHUNK.
- DONE:
  - out_valid=1.
  - eq, lt, gt and cycles are stable and exactly one of eq/lt/gt is 1.
  - in_ready=0; any in_valid is ignored and no operand is latched.
  - On out_valid&&out_ready: go to IDLE. out_valid drops the next cycle; eq, lt, gt and cycles keep their last values until the next capture clears them.
- No overlap between results: a new operand pair can be accepted no earlier than the cycle after the handoff.
- Boundary cases:
  - NCHUNK=1: single SCAN cycle.
  - CHUNK=WIDTH: degenerates to a 1-cycle compare.
  - x==y: never exits early.
  - Signed comparison of the most-negative value against the most-positive value is handled by the MSB inversion.
  - in_valid deasserting while in SCAN or DONE has no effect.
- Widths: cycles counts up to NCHUNK and must not wrap.

Test Plan:
WIDTH=16, CHUNK=4, EARLY_EXIT=1 unless stated.
1. x=y=16'h1234, unsigned -> eq=1, lt=gt=0, cycles=4; out_valid rises 4 cycles after accept.
2. x=16'h8000, y=16'h7FFF:
   - unsigned -> gt=1, cycles=1.
   - repeated with is_signed=1 -> lt=1, cycles=1.
3. x=16'h12A4, y=16'h12B4 -> lt=1, cycles=3. With EARLY_EXIT=0 -> lt=1, cycles=4, and the result is not overwritten by chunk 0.
4. Signed x=16'hFFFF (-1), y=16'hFFFE (-2) -> gt=1, cycles=4.
   - x=16'h0001, y=16'hFFFF -> gt=1, cycles=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid, eq, lt, gt and cycles stay constant; in_ready=0; the new operands are not captured. Assert out_ready -> IDLE the next cycle.
6. Reset: pull rst_n=0 for 2 cycles mid-SCAN -> out_valid, eq, lt, gt and cycles are 0 and in_ready is 0 during reset. After release in_ready=1 and the next compare (x=16'h0003, y=16'h0004 -> lt=1, cycles=4) is correct.

Source files
------------

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand/result bundle for seq_magnitude_comparator.
// The producer/consumer side uses master and the comparator uses slave.
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic             eq;
   logic             lt;
   logic             gt;
   logic [CW-1:0]    cycles;

   modport master (
      output in_valid, x, y, is_signed, out_ready,
      input  in_ready, out_valid, eq, lt, gt, cycles
   );

   modport slave (
      input  in_valid, x, y, is_signed, out_ready,
      output in_ready, out_valid, eq, lt, gt, cycles
   );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned/signed magnitude comparator that scans CHUNK bits per
// clock from the most-significant chunk down, with valid/ready on both sides.
module seq_magnitude_comparator #(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter bit EARLY_EXIT = 1'b1
) (
   input logic                       clk,
   input logic                       rst_n,
   seq_magnitude_comparator_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CW     = $clog2(NCHUNK + 1);
   localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDXW-1:0]  idx_q;
   logic [CW-1:0]    cycles_q;
   logic             eq_q;
   logic             lt_q;
   logic             gt_q;
   logic             found_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic             chunk_diff;
   logic             first_diff;
   logic             last_chunk;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;
   logic             handoff;

   always_comb begin
      a_chunk    = a_q[int'(idx_q) * CHUNK +: CHUNK];
      b_chunk    = b_q[int'(idx_q) * CHUNK +: CHUNK];
      chunk_diff = (a_chunk != b_chunk);
      first_diff = chunk_diff && !found_q;
      last_chunk = (idx_q == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if ((EARLY_EXIT && first_diff) || last_chunk) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (handoff) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // in_ready is masked by rst_n so nothing is offered while reset is held.
   always_comb begin
      in_ready_c  = rst_n && (state == IDLE);
      out_valid_c = (state == DONE);
      accept      = bus.in_valid && in_ready_c;
      handoff     = out_valid_c && bus.out_ready;
   end

   // Flipping both sign bits at capture turns a signed order into an unsigned
   // one, so the scan itself never needs to know the mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         cycles_q <= '0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         found_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q      <= bus.x ^ ({WIDTH{bus.is_signed}} & SIGN_BIT);
                  b_q      <= bus.y ^ ({WIDTH{bus.is_signed}} & SIGN_BIT);
                  idx_q    <= LAST_IDX;
                  cycles_q <= '0;
                  eq_q     <= 1'b0;
                  lt_q     <= 1'b0;
                  gt_q     <= 1'b0;
                  found_q  <= 1'b0;
               end
            end
            SCAN: begin
               cycles_q <= cycles_q + CW'(1);
               if (first_diff) begin
                  lt_q    <= (a_chunk < b_chunk);
                  gt_q    <= (a_chunk > b_chunk);
                  found_q <= 1'b1;
               end
               if (last_chunk && !found_q && !chunk_diff) begin
                  eq_q <= 1'b1;
               end
               if (!last_chunk) begin
                  idx_q <= idx_q - IDXW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.eq        = eq_q;
   assign bus.lt        = lt_q;
   assign bus.gt        = gt_q;
   assign bus.cycles    = cycles_q;

endmodule
